// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and stream framing.
package loader_pkg;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CHK    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word packer; emits a one-cycle word_valid after the 4th byte.
// LOADER_CHECKSUM_EN adds a running XOR of every packed byte.
module word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_last,
   output logic        word_valid,
   output logic [31:0] word
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  csum
`endif
);
   localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shreg_q, shreg_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   assign word_last  = byte_en && (cnt_q == LAST);
   assign word_valid = valid_q;
   assign word       = word_q;
`ifdef LOADER_CHECKSUM_EN
   assign csum       = csum_q;
`endif

   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      valid_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (clear) begin
         cnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
         csum_d = '0;
`endif
      end else if (byte_en) begin
`ifdef LOADER_CHECKSUM_EN
         csum_d = csum_q ^ byte_in;
`endif
         if (cnt_q == LAST) begin
            word_d  = {shreg_q, byte_in};
            valid_d = 1'b1;
            cnt_d   = '0;
         end else begin
            shreg_d = {shreg_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         word_q  <= word_d;
         valid_q <= valid_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed big-endian byte stream, pausing the core meanwhile.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        pause,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);
   localparam logic [32:0] CAP = 33'd1 << ADDR_W;

   logic [2:0]               state_q, state_d;
   logic [LEN_BYTES*8-1:0]   n_q, n_d;
   logic [15:0]              wl_q, wl_d;
   logic [15:0]              n_full;
   logic                     accept, word_last;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]               csum;
`endif

   assign rx_ready     = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
   assign accept       = rx_valid && rx_ready;
   assign n_full       = {n_q[15:8], rx_data};
   // The last word's write lands the cycle after the FSM reaches DONE, so hold pause over it.
   assign pause        = rx_ready || mem_we;
   assign busy         = pause;
   assign done         = (state_q == S_DONE) && !mem_we;
   assign error        = (state_q == S_ERROR);
   assign words_loaded = wl_q;
   assign mem_addr     = BASE_ADDR + {14'b0, wl_q, 2'b00};

   word_packer u_packer (
      .clk        (CLOCK_50),
      .reset      (reset),
      .clear      (start && (state_q inside {S_IDLE, S_DONE, S_ERROR})),
      .byte_en    (accept && (state_q == S_DATA)),
      .byte_in    (rx_data),
      .word_last  (word_last),
      .word_valid (mem_we),
      .word       (mem_wdata)
`ifdef LOADER_CHECKSUM_EN
      ,
      .csum       (csum)
`endif
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wl_d    = wl_q;
      if (mem_we) wl_d = wl_q + 16'd1;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR:
            if (start) begin
               state_d = S_LEN_HI;
               wl_d    = '0;
            end
         S_LEN_HI:
            if (accept) begin
               n_d[15:8] = rx_data;
               state_d   = S_LEN_LO;
            end
         S_LEN_LO:
            if (accept) begin
               n_d = n_full;
               if (n_full == 16'd0)               state_d = S_DONE;
               else if ({17'b0, n_full} > CAP)    state_d = S_ERROR;
               else                               state_d = S_DATA;
            end
         // Words never complete closer than 4 cycles apart, so no write is pending here.
         S_DATA:
            if (word_last && (wl_q + 16'd1 == n_q)) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
         S_CHK:
            if (accept) state_d = (rx_data == csum) ? S_DONE : S_ERROR;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         wl_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wl_q    <= wl_d;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2): directed cases plus randomized sessions against a stream-level model.
module tb_imem_loader;
   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        start    = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready, mem_we, pause, busy, done, error;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] words_loaded;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] wr_q[$];

   always #5 CLOCK_50 = ~CLOCK_50;

   imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .pause(pause), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge CLOCK_50) begin
      if (mem_we === 1'b1) begin
         wr_q.push_back({mem_addr, mem_wdata});
         chk("pause_during_write", {31'b0, pause}, 32'd1);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && t < 50) begin
         @(negedge CLOCK_50);
         t++;
      end
      if (t >= 50) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
      @(negedge CLOCK_50);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
      chk({tag, "_mem_we"},   {31'b0, mem_we},   32'd0);
      chk({tag, "_pause"},    {31'b0, pause},    32'd0);
      chk({tag, "_busy"},     {31'b0, busy},     32'd0);
      chk({tag, "_done"},     {31'b0, done},     32'd0);
      chk({tag, "_error"},    {31'b0, error},    32'd0);
      chk({tag, "_addr"},     mem_addr,          32'd0);
      chk({tag, "_wdata"},    mem_wdata,         32'd0);
      chk({tag, "_words"},    {16'b0, words_loaded}, 32'd0);
   endtask

   // Reference: decode the whole stream, then compare against the collected writes and final flags.
   task automatic run_session(input string tag, input logic [7:0] s[$], input int gap_max, input int stall_at);
      int          n, nw;
      logic        exp_ok;
      logic [7:0]  x;
      logic [31:0] w;
      n      = {s[0], s[1]};
      exp_ok = (n <= 4);
      nw     = exp_ok ? n : 0;
      x      = 8'h00;
      for (int i = 2; i < 2 + 4 * nw; i++) x ^= s[i];
`ifdef LOADER_CHECKSUM_EN
      if (nw > 0 && s.size() > 2 + 4 * nw) exp_ok = (s[2 + 4 * nw] == x);
`endif
      wr_q.delete();
      pulse_start();
      chk({tag, "_pause_start"}, {31'b0, pause}, 32'd1);
      for (int i = 0; i < s.size(); i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge CLOCK_50);
         if (i == stall_at) repeat (10) @(negedge CLOCK_50);
         send_byte(s[i]);
      end
      repeat (3) @(negedge CLOCK_50);
      chk({tag, "_done"},     {31'b0, done},     {31'b0, exp_ok});
      chk({tag, "_error"},    {31'b0, error},    {31'b0, !exp_ok});
      chk({tag, "_pause"},    {31'b0, pause},    32'd0);
      chk({tag, "_busy"},     {31'b0, busy},     32'd0);
      chk({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
      chk({tag, "_words"},    {16'b0, words_loaded}, nw);
      chk({tag, "_nwrites"},  wr_q.size(), nw);
      for (int i = 0; i < nw && i < wr_q.size(); i++) begin
         w = {s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]};
         chk({tag, "_addr"},  wr_q[i][63:32], 32'(4 * i));
         chk({tag, "_wdata"}, wr_q[i][31:0],  w);
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int         n;
      logic [7:0] x;

      repeat (3) @(negedge CLOCK_50);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge CLOCK_50);

      // Case 1: two-word program
      q = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      q.push_back(8'h2D);
`endif
      run_session("case1", q, 0, -1);

      // Case 2: empty program
      q = {8'h00, 8'h00};
      run_session("case2", q, 1, -1);

      // Case 3: length exceeds capacity, then further bytes must not be taken
      q = {8'h00, 8'h05};
      run_session("case3", q, 0, -1);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (5) @(negedge CLOCK_50);
      chk("case3_rx_ready_after", {31'b0, rx_ready}, 32'd0);
      chk("case3_no_writes", wr_q.size(), 32'd0);
      rx_valid = 1'b0;

      // Capacity boundary: exactly 2**ADDR_W words
      q = {8'h00, 8'h04};
      x = 8'h00;
      for (int i = 0; i < 16; i++) begin
         q.push_back(8'(i * 17 + 3));
         x ^= 8'(i * 17 + 3);
      end
`ifdef LOADER_CHECKSUM_EN
      q.push_back(x);
`endif
      run_session("full", q, 1, -1);

      // Case 4: 10-cycle stall in the middle of the second word
      q = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CHECKSUM_EN
      q.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
      run_session("case4", q, 0, 8);

      // Case 5: reset after two bytes of the second word
      wr_q.delete();
      pulse_start();
      q = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < q.size(); i++) send_byte(q[i]);
      chk("case5_prewrite", wr_q.size(), 32'd1);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check_reset_values("case5");
      reset = 1'b0;
      @(negedge CLOCK_50);
      q = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef LOADER_CHECKSUM_EN
      q.push_back(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
`endif
      run_session("case5_reload", q, 0, -1);

`ifdef LOADER_CHECKSUM_EN
      // Case 6: bad checksum still writes the words
      q = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
      run_session("case6_bad", q, 0, -1);
`endif

      // Randomized sessions
      for (int r = 0; r < 14; r++) begin
         n = $urandom_range(0, 6);
         q = {8'h00, 8'(n)};
         if (r == 3) q = {8'h01, 8'h02};
         if (n <= 4 && r != 3) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
               q.push_back(8'($urandom));
               x ^= q[q.size() - 1];
            end
`ifdef LOADER_CHECKSUM_EN
            if (n > 0) q.push_back(($urandom_range(0, 3) == 0) ? ~x : x);
`endif
         end
         run_session("rand", q, 2, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
